rr_arbiter: RTL and testbench
=============================

Name: rr_arbiter

Overview:
- Round-robin arbiter that shares one downstream resource among N requesters.
- Each request is a level-sensitive line. The holder keeps its grant until it releases, drops its request, or hits a hold-time limit.
- Selection uses a rotating priority encoder, so the last served requester becomes lowest priority.
- Sits in front of any shared datapath: encoder, bus, or memory port.

Parameters:
N, 8, number of requesters (2..16)
IDW, 3, width of grant_id, equal to clog2(N)
MAX_HOLD, 16, maximum cycles one grant may last; 0 disables the limit

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
req  input  N  request lines, bit i = requester i, level-held while wanting or using the resource
release_i  input  1  holder finished; honoured only while busy
grant  output  N  one-hot grant, all zero when idle
grant_id  output  IDW  binary index of current or most recent grantee
grant_valid  output  1  high while a grant is active (state BUSY)
timeout_o  output  1  one-cycle pulse when a grant is forcibly revoked by MAX_HOLD

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values: grant=0, grant_id=0, grant_valid=0, timeout_o=0, state=IDLE, hold counter=0, pointer ptr=N-1 (so requester 0 has top priority after reset).
- All outputs are registered. There is no combinational path from req or release_i to any output.
- States:
  - IDLE: no grant.
  - BUSY: one grant active.
- IDLE -> BUSY:
  - When req != 0, pick the first set bit scanning ptr+1, ptr+2, ... modulo N.
  - On the next edge: grant = onehot(pick), grant_id = pick, ptr = pick, grant_valid = 1, counter = 0.
  - Latency from req assertion to grant: 1 cycle.
- IDLE with req == 0: stay in IDLE; ptr unchanged.
- BUSY, end of grant:
  - The grant ends on the next edge if any of these holds: release_i=1, req[grant_id]=0, or (MAX_HOLD != 0 and counter == MAX_HOLD-1).
  - On that edge: grant = 0, grant_valid = 0, go to IDLE.
  - grant_id keeps its last value.
- BUSY, otherwise: counter increments; grant is unchanged.
- timeout_o:
  - Set for exactly one cycle on the edge that ends a grant by the MAX_HOLD condition only.
  - If release_i or a req drop coincides with the limit, the release wins and timeout_o stays 0.
- Arbitration gap:
  - There is always at least one IDLE cycle between consecutive grants.
  - A new selection is made in that IDLE cycle from the req value sampled then.
  - Requests arriving in BUSY only compete at the next arbitration.
- Fairness: with all N requesting continuously, grants cycle 0,1,...,N-1,0 in order. No requester waits more than N-1 grants.
- Non-holder request bits are ignored while BUSY. release_i is ignored in IDLE.
- Counter width is clog2(MAX_HOLD+1). The counter must not wrap while BUSY.
- Reset mid-grant: rst forces the reset values on the next edge, regardless of state. timeout_o is not pulsed.
- Single requester: it can be re-granted after each one-cycle gap.
- grant is always zero or one-hot. grant_valid == (grant != 0).

Decomposition:
- Package arb_pkg holds:
  - state enum {IDLE, BUSY};
  - default constants ARB_N=8 and ARB_IDW=3;
  - the onehot-from-index function.
- One sub-module, rr_prio_enc, is natural:
  - combinational rotating priority encoder;
  - inputs req[N] and ptr[IDW];
  - outputs pick[IDW] and any_req.
  - It masks and rotates the request vector, then uses the double-vector technique for the wrap-around search.
- rr_arbiter contains the FSM, pointer, hold counter and output registers.

Test Plan:
- Reset, then req=8'b1000_0001 held -> first grant=8'h01, grant_id=0. After release, one IDLE cycle, then grant=8'h80, grant_id=7. Next grant 8'h01 again.
- req=8'hFF held, release_i pulsed in every BUSY cycle -> grant_id sequence 0,1,2,...,7,0. grant_valid alternates 1,0. Never two grants without an IDLE gap.
- req=8'h04 only, no release, MAX_HOLD=16 -> grant_valid high for exactly 16 cycles. timeout_o is a single pulse on the revoking edge. Regrant of 8'h04 follows after 1 IDLE cycle.
- Holder req[2] drops mid-grant while req[5]=1 -> grant clears next edge with timeout_o=0. Next grant is 8'h20.
- release_i=1 coincides with counter==MAX_HOLD-1 -> grant ends and timeout_o stays 0. Separately, release_i pulsed while IDLE -> no effect.
- rst asserted in BUSY with grant=8'h10 -> next edge: grant=0, grant_valid=0, grant_id=0, timeout_o=0. With req=8'hFF afterwards, the first grant is 8'h01.

Source files
------------

// File: rtl/arb_pkg.sv
// rtl/arb_pkg.sv - shared types, defaults and helpers for the round-robin arbiter
package arb_pkg;

  localparam int ARB_N   = 8;
  localparam int ARB_IDW = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  // One-hot vector from a binary index; callers truncate to their own width.
  function automatic logic [15:0] onehot16(input logic [3:0] idx);
    return 16'(1) << idx;
  endfunction

endpackage

// File: rtl/rr_prio_enc.sv
// rtl/rr_prio_enc.sv - rotating priority encoder, first request after ptr wins
module rr_prio_enc #(
  parameter int N   = 8,
  parameter int IDW = 3
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [IDW-1:0] pick,
  output logic           any_req
);

  localparam logic [IDW:0] NW = (IDW+1)'(N);

  logic [N-1:0]   mask;
  logic [2*N-1:0] dbl;
  logic [IDW:0]   first;

  // Lower half holds only requests above ptr, upper half the full vector, so
  // the lowest set bit of the doubled vector is the wrap-around winner.
  always_comb begin
    mask = '0;
    for (int i = 0; i < N; i++) begin
      mask[i] = (IDW'(i) > ptr);
    end
    dbl   = {req, req & mask};
    first = '0;
    for (int i = 2*N-1; i >= 0; i--) begin
      if (dbl[i]) first = (IDW+1)'(i);
    end
    pick    = IDW'((first >= NW) ? (first - NW) : first);
    any_req = |req;
  end

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin arbiter with hold-time limit and registered outputs
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int IDW      = ARB_IDW,
  parameter int MAX_HOLD = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           release_i,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_id,
  output logic           grant_valid,
  output logic           timeout_o
);

  // A zero limit still needs a legal one-bit counter; it simply saturates.
  localparam int            CW  = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDW-1:0] id_q, id_d;
  logic           timeout_q, timeout_d;

  logic [IDW-1:0] pick;
  logic           any_req;
  logic           holder_req;
  logic           hold_hit;
  logic           end_grant;

  rr_prio_enc #(.N(N), .IDW(IDW)) u_enc (
    .req     (req),
    .ptr     (ptr_q),
    .pick    (pick),
    .any_req (any_req)
  );

  assign holder_req = req[id_q];
  assign hold_hit   = (MAX_HOLD != 0) && (cnt_q == LIM);
  assign end_grant  = release_i || !holder_req || hold_hit;

  // Next-state logic: arbitrate in IDLE, watch for the end of the grant in BUSY.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    id_d      = id_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          grant_d = N'(onehot16(4'(pick)));
          id_d    = pick;
          ptr_d   = pick;
          cnt_d   = '0;
        end
      end
      BUSY: begin
        if (end_grant) begin
          state_d   = IDLE;
          grant_d   = '0;
          cnt_d     = '0;
          // A release or request drop on the limit cycle counts as a normal end.
          timeout_d = hold_hit && !release_i && holder_req;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and output registers; reset leaves requester 0 with top priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IDW'(N - 1);
      cnt_q     <= '0;
      grant_q   <= '0;
      id_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      id_q      <= id_d;
      timeout_q <= timeout_d;
    end
  end

  assign grant       = grant_q;
  assign grant_id    = id_q;
  assign grant_valid = (state_q == BUSY);
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter.sv
// tb/tb_rr_arbiter.sv - directed and randomized checks of rr_arbiter against a reference model
module tb_rr_arbiter;

  localparam int N        = 8;
  localparam int IDW      = 3;
  localparam int MAX_HOLD = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic           release_i;
  logic [N-1:0]   grant;
  logic [IDW-1:0] grant_id;
  logic           grant_valid;
  logic           timeout_o;

  int checks   = 0;
  int failures = 0;

  // reference model state
  int m_busy, m_holder, m_last, m_cnt, m_gid, m_to;

  rr_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .release_i   (release_i),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .timeout_o   (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_holder = 0; m_last = N - 1; m_cnt = 0; m_gid = 0; m_to = 0;
  endtask

  // One clock edge of the arbiter, stated in terms of who holds the resource.
  task automatic model_edge(input logic [N-1:0] r, input logic rel, input logic rs);
    if (rs) begin
      model_reset();
    end else if (m_busy == 0) begin
      m_to = 0;
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_last + k) % N;
        if (r[idx] && m_busy == 0) begin
          m_busy = 1; m_holder = idx; m_gid = idx; m_last = idx; m_cnt = 0;
        end
      end
    end else begin
      bit limit;
      limit = (MAX_HOLD != 0) && (m_cnt == MAX_HOLD - 1);
      if (rel || !r[m_holder] || limit) begin
        m_to   = (!rel && r[m_holder]) ? 1 : 0;
        m_busy = 0;
      end else begin
        m_to  = 0;
        m_cnt = m_cnt + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] exp_grant;
    exp_grant = (m_busy != 0) ? (N'(1) << m_holder) : '0;
    compare({tag, ".grant"}, 32'(grant), 32'(exp_grant));
    compare({tag, ".grant_id"}, 32'(grant_id), 32'(m_gid));
    compare({tag, ".grant_valid"}, 32'(grant_valid), 32'(m_busy));
    compare({tag, ".timeout"}, 32'(timeout_o), 32'(m_to));
  endtask

  task automatic step(input logic [N-1:0] r, input logic rel, input logic rs, input string tag);
    @(negedge clk);
    req = r; release_i = rel; rst = rs;
    @(posedge clk);
    model_edge(r, rel, rs);
    #1;
    check_all(tag);
  endtask

  initial begin
    int ids[$];
    int hi, to_cnt, n;
    logic [N-1:0] rr;
    logic rl, rs;

    req = '0; release_i = 1'b0; rst = 1'b1;
    model_reset();

    // reset state
    step('0, 1'b0, 1'b1, "reset");
    step('0, 1'b0, 1'b1, "reset2");

    // two requesters at the ends of the vector
    step(8'h81, 1'b0, 1'b0, "t1.g0");
    compare("t1.first_grant", 32'(grant), 32'h01);
    step(8'h81, 1'b1, 1'b0, "t1.rel0");
    step(8'h81, 1'b0, 1'b0, "t1.g7");
    compare("t1.second_grant", 32'(grant), 32'h80);
    compare("t1.second_id", 32'(grant_id), 32'd7);
    step(8'h81, 1'b1, 1'b0, "t1.rel7");
    step(8'h81, 1'b0, 1'b0, "t1.g0b");
    compare("t1.third_grant", 32'(grant), 32'h01);

    // all requesting, release every busy cycle: strict rotation with gaps
    step('0, 1'b0, 1'b1, "t2.rst");
    for (int i = 0; i < 18; i++) begin
      step(8'hFF, grant_valid, 1'b0, "t2.rot");
      if (grant_valid) ids.push_back(int'(grant_id));
    end
    compare("t2.count", 32'(ids.size()), 32'd9);
    for (int i = 0; i < 9 && i < ids.size(); i++) begin
      compare("t2.order", 32'(ids[i]), 32'(i % N));
    end

    // single holder runs into the hold limit
    step('0, 1'b0, 1'b1, "t3.rst");
    step(8'h04, 1'b0, 1'b0, "t3.g");
    hi = grant_valid ? 1 : 0; to_cnt = 0; n = 0;
    while (grant_valid && n < 40) begin
      step(8'h04, 1'b0, 1'b0, "t3.hold");
      n++;
      if (grant_valid) hi++;
      if (timeout_o) to_cnt++;
    end
    compare("t3.busy_cycles", 32'(hi), 32'(MAX_HOLD));
    compare("t3.timeout_pulses", 32'(to_cnt), 32'd1);
    compare("t3.timeout_on_revoke", 32'(timeout_o), 32'd1);
    step(8'h04, 1'b0, 1'b0, "t3.regrant");
    compare("t3.regrant_grant", 32'(grant), 32'h04);
    compare("t3.pulse_cleared", 32'(timeout_o), 32'd0);

    // holder drops its request while another waits
    step('0, 1'b0, 1'b1, "t4.rst");
    step(8'h24, 1'b0, 1'b0, "t4.g2");
    compare("t4.first", 32'(grant), 32'h04);
    step(8'h24, 1'b0, 1'b0, "t4.hold");
    step(8'h20, 1'b0, 1'b0, "t4.drop");
    compare("t4.drop_grant", 32'(grant), 32'h00);
    compare("t4.drop_timeout", 32'(timeout_o), 32'd0);
    step(8'h20, 1'b0, 1'b0, "t4.g5");
    compare("t4.next", 32'(grant), 32'h20);

    // release on the limit cycle, then release while idle
    step('0, 1'b0, 1'b1, "t5.rst");
    step(8'h04, 1'b0, 1'b0, "t5.g");
    for (int i = 0; i < MAX_HOLD - 1; i++) step(8'h04, 1'b0, 1'b0, "t5.hold");
    step(8'h04, 1'b1, 1'b0, "t5.rel_at_limit");
    compare("t5.ended", 32'(grant_valid), 32'd0);
    compare("t5.no_timeout", 32'(timeout_o), 32'd0);
    step('0, 1'b1, 1'b0, "t5.idle_rel");
    step('0, 1'b1, 1'b0, "t5.idle_rel2");

    // reset in the middle of a grant
    step('0, 1'b0, 1'b1, "t6.rst");
    step(8'h10, 1'b0, 1'b0, "t6.g4");
    compare("t6.grant10", 32'(grant), 32'h10);
    step(8'hFF, 1'b0, 1'b1, "t6.mid_rst");
    compare("t6.rst_grant", 32'(grant), 32'h00);
    compare("t6.rst_id", 32'(grant_id), 32'd0);
    step(8'hFF, 1'b0, 1'b0, "t6.after");
    compare("t6.first_after", 32'(grant), 32'h01);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      rr = N'($urandom);
      if ($urandom_range(0, 3) == 0) rr = '0;
      rl = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 63) == 0);
      step(rr, rl, rs, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
